// File: rtl/ro_ctrl_pkg.sv
// Shared types and widths for the read_out capture sequencer.
// Word width is sized so a full 255-sample decimation of 3-bit codes never wraps.
package ro_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, DRAIN} ro_state_e;

    localparam int QZ_W    = 3;
    localparam int DECIM_W = 8;
    localparam int CNT_W   = 16;
    localparam int DW_DEF  = QZ_W + DECIM_W;

endpackage

// File: rtl/ro_capture_ctrl_if.sv
// Valid/ready word stream from the capture sequencer to the downstream filter/logger.
interface ro_capture_ctrl_if
    import ro_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
);

    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/ro_fifo.sv
// Synchronous word FIFO with a zero-bubble head; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module ro_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ro_capture_ctrl.sv
// Capture sequencer for read_out: owns the quantizer reset, waits out the settle window,
// decimates out_qz by accumulation and queues the words for a valid/ready consumer.
module ro_capture_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = DW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   cfg_settle,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic [CNT_W-1:0]   cfg_len,
    input  logic [QZ_W-1:0]    qz_in,
    output logic               ro_rst_n,
    ro_capture_ctrl_if.master  stream,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a, input logic [QZ_W-1:0] q);
        return a + DW'(q);
    endfunction

    ro_state_e          state_q, state_n;
    logic [CNT_W-1:0]   settle_q, len_q, settle_cnt_q, wcnt_q;
    logic [DECIM_W-1:0] decim_q, scnt_q;
    logic [DW-1:0]      acc_p0, word_p0;
    logic               start_ok, settle_end, word_end, len_end, pop, fifo_full, fifo_empty;

    assign start_ok   = (state_q == IDLE) && start;
    assign settle_end = ({1'b0, settle_cnt_q} + (CNT_W+1)'(1)) >= {1'b0, settle_q};
    assign word_end   = (state_q == RUN) && (({1'b0, scnt_q} + (DECIM_W+1)'(1)) == {1'b0, decim_q});
    assign len_end    = word_end && (len_q != '0) && ((wcnt_q + CNT_W'(1)) == len_q);
    assign word_p0    = acc_add(acc_p0, qz_in);
    assign pop        = stream.out_valid && stream.out_ready;
    assign stream.out_valid = !fifo_empty;

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (start) state_n = SETTLE;
            SETTLE:  if (stop) state_n = DRAIN; else if (settle_end) state_n = RUN;
            RUN:     if (stop || len_end) state_n = DRAIN;
            DRAIN:   if (fifo_empty) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy and ro_rst_n are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            ro_rst_n <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            busy     <= (state_n != IDLE);
            ro_rst_n <= (state_n == SETTLE) || (state_n == RUN);
            done     <= (state_q == DRAIN) && fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q     <= '0;
            len_q        <= '0;
            decim_q      <= DECIM_W'(1);
            settle_cnt_q <= '0;
            scnt_q       <= '0;
            wcnt_q       <= '0;
            ovf          <= 1'b0;
        end else if (start_ok) begin
            settle_q     <= cfg_settle;
            len_q        <= cfg_len;
            decim_q      <= (cfg_decim == '0) ? DECIM_W'(1) : cfg_decim;
            settle_cnt_q <= '0;
            scnt_q       <= '0;
            wcnt_q       <= '0;
            ovf          <= 1'b0;
        end else begin
            if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q + CNT_W'(1);
            if (word_end) begin
                scnt_q <= '0;
                wcnt_q <= wcnt_q + CNT_W'(1);
            end else if (state_q == RUN) begin
                scnt_q <= scnt_q + DECIM_W'(1);
            end
            // a dropped word still counts toward cfg_len
            if (word_end && fifo_full && !pop) ovf <= 1'b1;
        end
    end

    // Stage p0: accumulator; cleared on every push and on each new capture
    always_ff @(posedge clk) begin
        if (start_ok || word_end) acc_p0 <= '0;
        else if (state_q == RUN)  acc_p0 <= word_p0;
    end

    ro_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (word_end),
        .wdata (word_p0),
        .pop   (pop),
        .rdata (stream.out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ro_capture_ctrl.sv
// Bench for ro_capture_ctrl: expected words queued as stimulus is driven, checked as they are popped.
module tb_ro_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_settle = '0;
    logic [7:0]  cfg_decim = '0;
    logic [15:0] cfg_len = '0;
    logic [2:0]  qz_in = '0;
    logic        ro_rst_n, busy, done, ovf;

    int n_checks = 0;
    int n_errors = 0;
    int sb[$];

    ro_capture_ctrl_if #(.DW(11)) stream_if ();

    ro_capture_ctrl #(.DEPTH(8), .DW(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_settle (cfg_settle),
        .cfg_decim  (cfg_decim),
        .cfg_len    (cfg_len),
        .qz_in      (qz_in),
        .ro_rst_n   (ro_rst_n),
        .stream     (stream_if),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic [7:0] d, input logic [15:0] l);
        cfg_settle = s;
        cfg_decim  = d;
        cfg_len    = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
        cfg_settle = 16'hFFFF;
        cfg_decim  = 8'd3;
        cfg_len    = 16'd0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("idle_busy", busy, 0);
        check("idle_ro_rst_n", ro_rst_n, 0);
        step();
        check("done_one_cycle", done, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && stream_if.out_valid && stream_if.out_ready) begin
            check("sb_has_word", (sb.size() > 0), 1);
            if (sb.size() > 0) check("word", stream_if.out_data, sb.pop_front());
        end
    end

    initial begin
        stream_if.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        step();
        step();
        check("rst_ro_rst_n", ro_rst_n, 0);
        check("rst_out_valid", stream_if.out_valid, 0);
        check("rst_out_data", stream_if.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // idle without start
        for (int i = 0; i < 1000; i++) begin
            step();
            check("idle_ro_rst_n", ro_rst_n, 0);
            check("idle_out_valid", stream_if.out_valid, 0);
            check("idle_busy", busy, 0);
        end

        // settle 20, decim 4, three words of 5*4
        stream_if.out_ready = 1'b1;
        qz_in = 3'd5;
        for (int i = 0; i < 3; i++) sb.push_back(20);
        check("pre_start_ro_rst_n", ro_rst_n, 0);
        pulse_start(16'd20, 8'd4, 16'd3);
        check("start_ro_rst_n", ro_rst_n, 1);
        check("start_busy", busy, 1);
        for (int i = 0; i < 23; i++) step();
        check("first_word_not_yet", stream_if.out_valid, 0);
        step();
        check("first_word_valid", stream_if.out_valid, 1);
        wait_done(40);

        // decim 0 acts as 1: words follow a 0..7 ramp
        pulse_start(16'd3, 8'd0, 16'd8);
        for (int i = 0; i < 3; i++) step();
        for (int k = 0; k < 8; k++) begin
            qz_in = 3'(k);
            sb.push_back(k);
            step();
        end
        qz_in = 3'd0;
        wait_done(20);

        // full-scale decimation
        qz_in = 3'd7;
        sb.push_back(1785);
        pulse_start(16'd0, 8'd255, 16'd1);
        wait_done(300);

        // overflow: 12 words into a depth-8 FIFO with the consumer stalled
        stream_if.out_ready = 1'b0;
        pulse_start(16'd0, 8'd1, 16'd12);
        step();
        for (int k = 0; k < 12; k++) begin
            qz_in = 3'((k % 7) + 1);
            if (k < 8) sb.push_back((k % 7) + 1);
            step();
        end
        check("ovf_set", ovf, 1);
        check("ovf_valid_held", stream_if.out_valid, 1);
        check("ovf_drain_busy", busy, 1);
        check("ovf_drain_ro_rst_n", ro_rst_n, 0);
        stream_if.out_ready = 1'b1;
        wait_done(30);
        check("ovf_sticky", ovf, 1);

        // stop mid-word with cfg_len 0; a start during DRAIN is ignored
        stream_if.out_ready = 1'b0;
        qz_in = 3'd3;
        sb.push_back(12);
        sb.push_back(12);
        pulse_start(16'd2, 8'd4, 16'd0);
        check("ovf_cleared", ovf, 0);
        for (int i = 0; i < 12; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_ro_rst_n", ro_rst_n, 0);
        check("stop_busy", busy, 1);
        pulse_start(16'd0, 8'd1, 16'd1);
        check("drain_start_ignored", busy, 1);
        check("drain_done_low", done, 0);
        stream_if.out_ready = 1'b1;
        wait_done(20);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_restart_busy", busy, 0);
        end

        // asynchronous reset while running
        stream_if.out_ready = 1'b0;
        qz_in = 3'd1;
        pulse_start(16'd1, 8'd2, 16'd0);
        for (int i = 0; i < 10; i++) step();
        check("run_busy", busy, 1);
        check("run_words_held", stream_if.out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", stream_if.out_valid, 0);
        check("arst_out_data", stream_if.out_data, 0);
        check("arst_ro_rst_n", ro_rst_n, 0);
        step();
        step();
        rst_n = 1'b1;
        stream_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_arst_empty", stream_if.out_valid, 0);
            check("post_arst_idle", busy, 0);
        end

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ro_capture_ctrl.md
# ro_capture_ctrl

Capture sequencer for the VCO delta-modulation readout path. It owns the `read_out` quantizer's reset, holds it through a programmable settle window, then decimates the 3-bit `out_qz` stream by accumulation. Each decimated word is buffered in a small FIFO and delivered over a valid/ready interface to the downstream filter/logger. It replaces the fixed-delay reset-then-stream sequencing currently done by hand around `read_out`.

## Interface
- `DEPTH`, 8: FIFO depth in words, power of two ≥ 2.
- `DW`, 11: output word width; holds 7 × 255 = 1785.
- `clk` input 1: single clock, same clock as `read_out`.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a capture from IDLE, ignored elsewhere.
- `stop` input 1: one-cycle pulse; aborts SETTLE/RUN.
- `cfg_settle` input 16: settle cycles discarded after quantizer reset release.
- `cfg_decim` input 8: samples per word; 0 treated as 1.
- `cfg_len` input 16: words per capture; 0 means run until `stop`.
- `qz_in` input 3: `out_qz` from `read_out`, unsigned 0..7.
- `ro_rst_n` output 1: registered active-low reset to `read_out`.
- `out_data` output DW: accumulated word (FIFO head).
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accept.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse on DRAIN→IDLE.
- `ovf` output 1: sticky overflow; cleared on accepted `start`.

## Operation
- Config is latched on accepted `start` and ignored until the next capture.
- States:
  - IDLE: `ro_rst_n`=0, no accumulation. `start` → SETTLE.
  - SETTLE: `ro_rst_n`=1, counter counts `cfg_settle` cycles, `qz_in` ignored.
    - count reaches `cfg_settle` → RUN.
    - `cfg_settle`=0 → RUN after exactly one SETTLE cycle.
  - RUN: every cycle `acc += qz_in`, `scnt++`.
    - When `scnt` reaches `cfg_decim`, push `acc + qz_in`, clear `acc`/`scnt`, increment `wcnt`.
    - `wcnt` reaches `cfg_len` (nonzero) → DRAIN on the push cycle.
  - `stop` in SETTLE or RUN → DRAIN; a partial accumulation is discarded, never pushed.
  - DRAIN: `ro_rst_n`=0. FIFO empty → IDLE with `done`=1 for one cycle.
  - `start` or `stop` in DRAIN or IDLE-with-no-capture: ignored.
- Push with FIFO full: the word is dropped, `ovf` is set, `wcnt` still increments, and capture continues.
- Push and pop in the same cycle with FIFO full: the pop frees the slot, so the push succeeds and there is no overflow.
- `stop` and a push in the same RUN cycle: the push completes, then → DRAIN.
- Reset mid-capture: FIFO flushed, all counters cleared, state → IDLE.

## Timing
- Reset values: `ro_rst_n`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `ovf`=0, FSM=IDLE.
- `start` sampled at edge N: SETTLE from N+1, `ro_rst_n`=1 from N+1.
- First RUN cycle is N+1+max(`cfg_settle`,1); first `qz_in` accumulated at that edge.
- Word complete at edge M: `out_valid`=1 and `out_data` valid from M+1 (registered FIFO write, zero-bubble read).
- Pop: `out_valid` & `out_ready` at an edge; next word presented the following cycle.
- Throughput is 1 word per `cfg_decim` cycles; sustained `out_ready` low fills the FIFO in DEPTH words.
- `busy` is registered and follows state with no extra delay.

## Structure
- Package `ro_ctrl_pkg`:
  - state enum `{IDLE, SETTLE, RUN, DRAIN}`
  - `QZ_W`=3, `DECIM_W`=8, `CNT_W`=16
  - `DW` default derived from `QZ_W`/`DECIM_W`
- Sub-module `ro_fifo`: synchronous FIFO (DEPTH, DW) with push/pop/full/empty, simultaneous push+pop allowed when full.
- Top: FSM, settle/sample/word counters, accumulator, `ovf` flag.

## Test plan
- Reset release, no `start` → `ro_rst_n`=0, `out_valid`=0, `busy`=0 for 1000 cycles.
- `cfg_settle`=20, `cfg_decim`=4, `cfg_len`=3, `qz_in` held at 5, `out_ready`=1 → three words of 20 each; `ro_rst_n` rises 1 cycle after `start`; `done` pulse follows the last pop; `ro_rst_n`=0 afterwards.
- `cfg_decim`=0, `qz_in` ramps 0..7, `cfg_len`=8 → words equal the `qz_in` sequence 0..7 (decim 1).
- `cfg_decim`=255, `qz_in`=7 → word 1785, no wrap.
- DEPTH=8, `cfg_decim`=1, `cfg_len`=12, `out_ready`=0 → 8 words retained, `ovf`=1; then `out_ready`=1 drains words 1..8 and `done` pulses. `ovf` clears on the next `start`.
- `cfg_len`=0, `stop` mid-accumulation (`scnt`=2 of 4) → partial word not pushed, DRAIN→IDLE, `done`=1. A second `start` during DRAIN is ignored. An async `rst_n` pulse in RUN → immediate IDLE and empty FIFO.
